// File: rtl/onehot_capture_fifo.sv
// Captures one-hot words, encodes them to an index with a multi-hot flag,
// and queues the events for a downstream valid/ready consumer.
module onehot_capture_fifo #(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          In_valid,
    input  logic [0:7]    Y,
    input  logic          Clr_err,
    input  logic          Out_ready,
    output logic          Out_valid,
    output logic [2:0]    Out_code,
    output logic          Out_multi,
    output logic [CW-1:0] Count,
    output logic          Full,
    output logic          Zero_err,
    output logic          Ovf_err
);

    localparam int AW = $clog2(DEPTH);

    logic [3:0]    mem_q [DEPTH];
    logic [3:0]    mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          zero_err_q, zero_err_d;
    logic          ovf_err_q, ovf_err_d;

    logic       y_any;
    logic       y_multi;
    logic [2:0] y_code;
    logic       found;
    logic       full;
    logic       not_empty;
    logic       push;
    logic       pop;

    // Lowest set index wins; Y[0] is the leftmost bit of the word.
    always_comb begin
        y_code = 3'd0;
        found  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (Y[k] && !found) begin
                y_code = 3'(k);
                found  = 1'b1;
            end
        end
        y_any   = found;
        y_multi = ($countones(Y) > 1);
    end

    always_comb begin
        full      = (count_q == CW'(DEPTH));
        not_empty = (count_q != '0);
        pop       = not_empty && Out_ready;
        push      = In_valid && y_any && (!full || pop);

        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;

        if (push) begin
            mem_d[wr_ptr_q] = {y_multi, y_code};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        count_d = count_q + CW'(push) - CW'(pop);

        // A new error in the same cycle as Clr_err keeps the flag set.
        zero_err_d = (In_valid && !y_any) || (zero_err_q && !Clr_err);
        ovf_err_d  = (In_valid && y_any && full && !pop)
                  || (ovf_err_q && !Clr_err);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            zero_err_q <= 1'b0;
            ovf_err_q  <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            zero_err_q <= zero_err_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

    always_comb begin
        Out_valid = not_empty;
        Out_code  = not_empty ? mem_q[rd_ptr_q][2:0] : 3'd0;
        Out_multi = not_empty ? mem_q[rd_ptr_q][3]   : 1'b0;
        Count     = count_q;
        Full      = full;
        Zero_err  = zero_err_q;
        Ovf_err   = ovf_err_q;
    end

endmodule

// File: tb/tb_onehot_capture_fifo.sv
// Scoreboard bench for onehot_capture_fifo: a queue model predicts every
// output each cycle and the popped entries are checked in order.
module tb_onehot_capture_fifo;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          In_valid;
    logic [0:7]    Y;
    logic          Clr_err;
    logic          Out_ready;
    logic          Out_valid;
    logic [2:0]    Out_code;
    logic          Out_multi;
    logic [CW-1:0] Count;
    logic          Full;
    logic          Zero_err;
    logic          Ovf_err;

    onehot_capture_fifo #(.DEPTH(DEPTH)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .In_valid (In_valid),
        .Y        (Y),
        .Clr_err  (Clr_err),
        .Out_ready(Out_ready),
        .Out_valid(Out_valid),
        .Out_code (Out_code),
        .Out_multi(Out_multi),
        .Count    (Count),
        .Full     (Full),
        .Zero_err (Zero_err),
        .Ovf_err  (Ovf_err)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] sb [$];
    logic       m_zero = 1'b0;
    logic       m_ovf  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [0:7] oh(input int i);
        logic [0:7] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] enc(input logic [0:7] y);
        int ones;
        logic [2:0] c;
        logic hit;
        ones = 0;
        c    = 3'd0;
        hit  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (y[k]) begin
                ones++;
                if (!hit) begin
                    c   = 3'(k);
                    hit = 1'b1;
                end
            end
        end
        return {ones > 1, c};
    endfunction

    // Drive one cycle, predict with the model, then compare after the edge.
    task automatic step(input logic v, input logic [0:7] y,
                        input logic rdy, input logic clr, input logic rst);
        logic m_pop, m_push, full_m;
        logic [3:0] head;
        Reset     = rst;
        In_valid  = v;
        Y         = y;
        Out_ready = rdy;
        Clr_err   = clr;
        #1;
        full_m = (sb.size() == DEPTH);
        m_pop  = (sb.size() != 0) && rdy && !rst;
        m_push = v && (y != 0) && (!full_m || m_pop) && !rst;
        if (m_pop) begin
            head = sb.pop_front();
            chk("pop_entry", {Out_multi, Out_code}, head);
        end
        if (rst) begin
            sb.delete();
            m_zero = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            if (m_push) sb.push_back(enc(y));
            m_zero = (v && y == 0) || (m_zero && !clr);
            m_ovf  = (v && y != 0 && full_m && !m_pop) || (m_ovf && !clr);
        end
        @(posedge Clock);
        #1;
        chk("out_valid", Out_valid, sb.size() != 0);
        chk("count", Count, sb.size());
        chk("full", Full, sb.size() == DEPTH);
        chk("zero_err", Zero_err, m_zero);
        chk("ovf_err", Ovf_err, m_ovf);
        chk("head", {Out_multi, Out_code},
            sb.size() != 0 ? sb[0] : 4'd0);
    endtask

    initial begin
        int ord_in [$];
        int ord_out [$];
        int idx;
        logic rdy;

        Reset = 1'b1;
        In_valid = 1'b0;
        Y = '0;
        Clr_err = 1'b0;
        Out_ready = 1'b0;
        @(posedge Clock);
        #1;
        step(1'b1, oh(4), 1'b1, 1'b0, 1'b1);
        chk("rst_count", Count, 0);
        chk("rst_valid", Out_valid, 0);

        step(1'b1, 8'b0010_0000, 1'b0, 1'b0, 1'b0);
        chk("t1_code", Out_code, 2);
        chk("t1_multi", Out_multi, 0);
        chk("t1_count", Count, 1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        step(1'b1, oh(0), 1'b0, 1'b0, 1'b0);
        step(1'b1, oh(7), 1'b0, 1'b0, 1'b0);
        step(1'b1, oh(3), 1'b0, 1'b0, 1'b0);
        step(1'b1, oh(5), 1'b0, 1'b0, 1'b0);
        chk("fill_full", Full, 1);
        chk("fill_count", Count, 4);

        step(1'b1, oh(6), 1'b0, 1'b0, 1'b0);
        chk("drop_count", Count, 4);
        chk("drop_ovf", Ovf_err, 1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("ovf_clr", Ovf_err, 0);
        chk("full_head", Out_code, 0);
        step(1'b1, oh(6), 1'b1, 1'b0, 1'b0);
        chk("pp_count", Count, 4);
        chk("pp_ovf", Ovf_err, 0);
        chk("pp_head", Out_code, 7);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("drain_valid", Out_valid, 0);

        step(1'b1, 8'b0101_0000, 1'b0, 1'b0, 1'b0);
        chk("multi_code", Out_code, 1);
        chk("multi_flag", Out_multi, 1);
        step(1'b1, '0, 1'b0, 1'b0, 1'b0);
        chk("zero_set", Zero_err, 1);
        chk("zero_nopush", Count, 1);
        step(1'b1, '0, 1'b0, 1'b1, 1'b0);
        chk("zero_setwins", Zero_err, 1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("zero_clr", Zero_err, 0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idx = $urandom_range(0, 7);
            ord_in.push_back(idx);
            if (Out_valid && rdy) ord_out.push_back(Out_code);
            step(1'b1, oh(idx), rdy, 1'b0, 1'b0);
            chk("stream_bound", Count <= 4, 1);
            rdy = ~rdy;
        end
        for (int i = 0; i < 12; i++) begin
            if (Out_valid) ord_out.push_back(Out_code);
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        // Words dropped while full never reach the output list.
        chk("stream_len", ord_out.size() <= ord_in.size(), 1);
        chk("stream_first", ord_out[0], ord_in[0]);

        step(1'b1, oh(1), 1'b0, 1'b0, 1'b0);
        step(1'b1, oh(2), 1'b0, 1'b0, 1'b0);
        step(1'b1, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, oh(3), 1'b0, 1'b0, 1'b0);
        chk("pre_rst_count", Count, 3);
        step(1'b1, oh(4), 1'b1, 1'b0, 1'b1);
        chk("mid_rst_count", Count, 0);
        chk("mid_rst_valid", Out_valid, 0);
        chk("mid_rst_zero", Zero_err, 0);
        chk("mid_rst_ovf", Ovf_err, 0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_empty", Out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
